// File: rtl/dsp_execute_if.sv
// Decoded-instruction handshake from decode into the execute stage.
// Fields are sampled only in the cycle where instr_valid and instr_ready are both high.
// Decode holds the fields while instr_ready is low.
interface dsp_execute_if #(
    parameter int AW = 16
);
    logic          instr_valid;
    logic          instr_ready;
    logic [7:0]    alu_mode;
    logic          r_w;
    logic [2:0]    mem_mode;
    logic [2:0]    flow_mode;
    logic [15:0]   reg_s1;
    logic [15:0]   reg_s2;
    logic [15:0]   reg_dst;
    logic [AW-1:0] address;

    modport master (
        output instr_valid, alu_mode, r_w, mem_mode, flow_mode,
               reg_s1, reg_s2, reg_dst, address,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, alu_mode, r_w, mem_mode, flow_mode,
               reg_s1, reg_s2, reg_dst, address,
        output instr_ready
    );
endinterface

// File: rtl/dsp_execute.sv
// Execute/memory/writeback stage: ALU, bank I/II access, regfile writeback, jumps, retire count.
// Latency: ALU/store/jump finish 1 cycle after accept, loads 2; ready again the cycle after.
// Backpressure: instr_ready low while busy or halted. DSP_EXEC_SAT_EN saturates ADD/SUB/MAC.
module dsp_execute #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int RA = 4
) (
    input  logic          clk,
    input  logic          rst,
    dsp_execute_if.slave  ins,
    output logic [RA-1:0] rf_read_addr_1,
    output logic [RA-1:0] rf_read_addr_2,
    output logic [RA-1:0] rf_read_addr_3,
    input  logic [DW-1:0] rf_read_data_1,
    input  logic [DW-1:0] rf_read_data_2,
    input  logic [DW-1:0] rf_read_data_3,
    output logic [RA-1:0] rf_write_addr,
    output logic [DW-1:0] rf_write_data,
    output logic          rf_write_en,
    output logic [AW-1:0] read_addr_1,
    input  logic [DW-1:0] read_data_1,
    output logic [AW-1:0] read_addr_2,
    output logic [AW-1:0] write_addr_2,
    input  logic [DW-1:0] read_data_2,
    output logic [DW-1:0] write_data_2,
    output logic          write_en_2,
    output logic [AW-1:0] jump_addr,
    output logic          jump_flag,
    output logic          halted,
    output logic [31:0]   retired
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WAIT, S_HALT} state_t;

    localparam logic [2:0] MEM_BANK1 = 3'd1;
    localparam logic [2:0] MEM_BANK2 = 3'd2;
    localparam logic [2:0] FL_JMP    = 3'd1;
    localparam logic [2:0] FL_BZ     = 3'd2;
    localparam logic [2:0] FL_BNZ    = 3'd3;
    localparam logic [2:0] FL_BNEG   = 3'd4;
    localparam logic [2:0] FL_HALT   = 3'd5;

    state_t        state_q, state_d;
    logic [7:0]    alu_q, alu_d;
    logic          rw_q, rw_d;
    logic [2:0]    mem_q, mem_d;
    logic [2:0]    flow_q, flow_d;
    logic [RA-1:0] s1_q, s1_d, s2_q, s2_d, dst_q, dst_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] jaddr_q, jaddr_d;
    logic          halted_q, halted_d;
    logic [31:0]   retired_q, retired_d;

    logic          is_bank1, is_bank2, is_load, is_store, alu_wr, taken;
    logic [DW-1:0] prod_lo, add_res, sub_res, mac_res, alu_res;
    logic [3:0]    shamt;
    logic          unused_idx_hi;

    // Register indices are 16 bits on the bus but only the low RA bits address the file.
    assign unused_idx_hi = ^{ins.reg_s1[15:RA], ins.reg_s2[15:RA], ins.reg_dst[15:RA]};

    assign rf_read_addr_1 = s1_q;
    assign rf_read_addr_2 = s2_q;
    assign rf_read_addr_3 = dst_q;
    assign read_addr_1    = addr_q;
    assign read_addr_2    = addr_q;
    assign halted         = halted_q;
    assign retired        = retired_q;

    assign is_bank1 = (mem_q == MEM_BANK1);
    assign is_bank2 = (mem_q == MEM_BANK2);
    assign is_load  = (is_bank1 || is_bank2) && !rw_q;
    assign is_store = is_bank2 && rw_q;
    assign alu_wr   = (alu_q >= 8'd1) && (alu_q <= 8'd9);
    assign shamt    = rf_read_data_2[3:0];
    // Low half of a product is identical for signed and unsigned operands.
    assign prod_lo  = rf_read_data_1 * rf_read_data_2;

`ifdef DSP_EXEC_SAT_EN
    function automatic logic [DW-1:0] sat(input logic [DW:0] w);
        if (w[DW] != w[DW-1])
            return w[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return w[DW-1:0];
    endfunction

    assign add_res = sat({rf_read_data_1[DW-1], rf_read_data_1} + {rf_read_data_2[DW-1], rf_read_data_2});
    assign sub_res = sat({rf_read_data_1[DW-1], rf_read_data_1} - {rf_read_data_2[DW-1], rf_read_data_2});
    assign mac_res = sat({rf_read_data_3[DW-1], rf_read_data_3} + {prod_lo[DW-1], prod_lo});
`else
    assign add_res = rf_read_data_1 + rf_read_data_2;
    assign sub_res = rf_read_data_1 - rf_read_data_2;
    assign mac_res = rf_read_data_3 + prod_lo;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_q)
            8'd1:    alu_res = add_res;
            8'd2:    alu_res = sub_res;
            8'd3:    alu_res = rf_read_data_1 & rf_read_data_2;
            8'd4:    alu_res = rf_read_data_1 | rf_read_data_2;
            8'd5:    alu_res = rf_read_data_1 ^ rf_read_data_2;
            8'd6:    alu_res = rf_read_data_1 << shamt;
            8'd7:    alu_res = DW'($signed(rf_read_data_1) >>> shamt);
            8'd8:    alu_res = prod_lo;
            8'd9:    alu_res = mac_res;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (flow_q)
            FL_JMP:  taken = 1'b1;
            FL_BZ:   taken = (rf_read_data_1 == '0);
            FL_BNZ:  taken = (rf_read_data_1 != '0);
            FL_BNEG: taken = rf_read_data_1[DW-1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        alu_d           = alu_q;
        rw_d            = rw_q;
        mem_d           = mem_q;
        flow_d          = flow_q;
        s1_d            = s1_q;
        s2_d            = s2_q;
        dst_d           = dst_q;
        addr_d          = addr_q;
        jaddr_d         = jaddr_q;
        halted_d        = halted_q;
        retired_d       = retired_q;
        ins.instr_ready = 1'b0;
        rf_write_en     = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        write_en_2      = 1'b0;
        write_addr_2    = '0;
        write_data_2    = '0;
        jump_flag       = 1'b0;
        jump_addr       = jaddr_q;

        case (state_q)
            S_IDLE: begin
                ins.instr_ready = 1'b1;
                if (ins.instr_valid) begin
                    alu_d   = ins.alu_mode;
                    rw_d    = ins.r_w;
                    mem_d   = ins.mem_mode;
                    flow_d  = ins.flow_mode;
                    s1_d    = ins.reg_s1[RA-1:0];
                    s2_d    = ins.reg_s2[RA-1:0];
                    dst_d   = ins.reg_dst[RA-1:0];
                    addr_d  = ins.address;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Any bank access (including a dropped bank I store) suppresses ALU writeback.
                if (!is_bank1 && !is_bank2 && alu_wr) begin
                    rf_write_en   = 1'b1;
                    rf_write_addr = dst_q;
                    rf_write_data = alu_res;
                end
                if (is_store) begin
                    write_en_2   = 1'b1;
                    write_addr_2 = addr_q;
                    write_data_2 = rf_read_data_1;
                end
                if (taken) begin
                    jump_flag = 1'b1;
                    jump_addr = addr_q;
                    jaddr_d   = addr_q;
                end
                if (is_load) begin
                    state_d = S_MEM_WAIT;
                end else begin
                    retired_d = retired_q + 32'd1;
                    if (flow_q == FL_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_MEM_WAIT: begin
                rf_write_en   = 1'b1;
                rf_write_addr = dst_q;
                rf_write_data = is_bank1 ? read_data_1 : read_data_2;
                retired_d     = retired_q + 32'd1;
                if (flow_q == FL_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            alu_q     <= '0;
            rw_q      <= 1'b0;
            mem_q     <= '0;
            flow_q    <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            dst_q     <= '0;
            addr_q    <= '0;
            jaddr_q   <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            alu_q     <= alu_d;
            rw_q      <= rw_d;
            mem_q     <= mem_d;
            flow_q    <= flow_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            dst_q     <= dst_d;
            addr_q    <= addr_d;
            jaddr_q   <= jaddr_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

endmodule
